// File: rtl/gs_mixer.sv
// gs_mixer: N-channel sample mixer for the General Sound block.
// Live per-channel sample/volume/pan registers are snapshotted once per output
// sample period and mixed by a single time-multiplexed multiply-accumulate
// into saturated signed stereo PCM with a one-cycle new-sample strobe.
module gs_mixer #(
    parameter int CHANNELS   = 4,
    parameter int SAMPLE_W   = 8,
    parameter int VOL_W      = 6,
    parameter int OUT_W      = 16,
    parameter int SAMPLE_DIV = 272
) (
    input  logic                clk12mhz,
    input  logic                nRESET,
    input  logic                smp_we,
    input  logic [2:0]          smp_ch,
    input  logic [SAMPLE_W-1:0] smp_data,
    input  logic                vol_we,
    input  logic [2:0]          vol_ch,
    input  logic [VOL_W-1:0]    vol_data,
    input  logic                pan_we,
    input  logic [2:0]          pan_ch,
    input  logic [1:0]          pan_data,
    output logic [OUT_W-1:0]    sndLeft,
    output logic [OUT_W-1:0]    sndRight,
    output logic                snd_strobe,
    output logic                busy
);

    // Product carries one guard bit so the signed*unsigned multiply is exact;
    // its value always fits SAMPLE_W+VOL_W bits.
    localparam int P_W   = SAMPLE_W + VOL_W + 1;
    localparam int ACC_W = SAMPLE_W + VOL_W + 3;
    localparam int SH    = OUT_W - SAMPLE_W - VOL_W;
    localparam int SHW   = ACC_W + SH;
    localparam int DIV_W = $clog2(SAMPLE_DIV);

    localparam logic [DIV_W-1:0]    DIV_LAST    = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [2:0]          K_LAST      = 3'(CHANNELS - 1);
    localparam logic [SAMPLE_W-1:0] SMP_SILENCE = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic signed [SHW-1:0] SAT_MAX   = {{(SHW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SHW-1:0] SAT_MIN   = {{(SHW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ACC  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    // Clamp the scaled accumulator into the signed output range.
    function automatic logic [OUT_W-1:0] sat_f(input logic signed [SHW-1:0] v);
        logic [OUT_W-1:0] r;
        if (v > SAT_MAX) begin
            r = SAT_MAX[OUT_W-1:0];
        end else if (v < SAT_MIN) begin
            r = SAT_MIN[OUT_W-1:0];
        end else begin
            r = v[OUT_W-1:0];
        end
        return r;
    endfunction

    state_t state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [2:0] k_q, k_d;
    logic signed [ACC_W-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic [OUT_W-1:0] snd_l_q, snd_l_d, snd_r_q, snd_r_d;
    logic strobe_q, strobe_d, busy_q, busy_d;

    logic [SAMPLE_W-1:0] smp_q [CHANNELS];
    logic [SAMPLE_W-1:0] smp_d [CHANNELS];
    logic [VOL_W-1:0]    vol_q [CHANNELS];
    logic [VOL_W-1:0]    vol_d [CHANNELS];
    logic [1:0]          pan_q [CHANNELS];
    logic [1:0]          pan_d [CHANNELS];
    logic [SAMPLE_W-1:0] sh_smp_q [CHANNELS];
    logic [SAMPLE_W-1:0] sh_smp_d [CHANNELS];
    logic [VOL_W-1:0]    sh_vol_q [CHANNELS];
    logic [VOL_W-1:0]    sh_vol_d [CHANNELS];
    logic [1:0]          sh_pan_q [CHANNELS];
    logic [1:0]          sh_pan_d [CHANNELS];

    logic                       tick_s;
    logic [SAMPLE_W-1:0]        cur_smp_s;
    logic [VOL_W-1:0]           cur_vol_s;
    logic [1:0]                 cur_pan_s;
    logic signed [SAMPLE_W-1:0] smp_signed_s;
    logic signed [P_W-1:0]      s_ext_s, v_ext_s, prod_s;
    logic signed [SHW-1:0]      shl_l_s, shl_r_s;

    // Next-state logic: register-file writes, divider, MAC sequencing, outputs.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        k_d      = k_q;
        acc_l_d  = acc_l_q;
        acc_r_d  = acc_r_q;
        snd_l_d  = snd_l_q;
        snd_r_d  = snd_r_q;
        strobe_d = 1'b0;
        sh_smp_d = sh_smp_q;
        sh_vol_d = sh_vol_q;
        sh_pan_d = sh_pan_q;
        cur_smp_s = SMP_SILENCE;
        cur_vol_s = {VOL_W{1'b0}};
        cur_pan_s = 2'b00;

        // Live registers: indices beyond CHANNELS never match any slot.
        for (int i = 0; i < CHANNELS; i++) begin
            smp_d[i] = (smp_we && (smp_ch == 3'(i))) ? smp_data : smp_q[i];
            vol_d[i] = (vol_we && (vol_ch == 3'(i))) ? vol_data : vol_q[i];
            pan_d[i] = (pan_we && (pan_ch == 3'(i))) ? pan_data : pan_q[i];
        end

        tick_s = (cnt_q == DIV_LAST);
        cnt_d  = tick_s ? {DIV_W{1'b0}} : cnt_q + DIV_W'(1);

        // Channel selected by k from the frame snapshot.
        for (int i = 0; i < CHANNELS; i++) begin
            cur_smp_s = (k_q == 3'(i)) ? sh_smp_q[i] : cur_smp_s;
            cur_vol_s = (k_q == 3'(i)) ? sh_vol_q[i] : cur_vol_s;
            cur_pan_s = (k_q == 3'(i)) ? sh_pan_q[i] : cur_pan_s;
        end

        // Offset-binary to two's complement is an MSB flip.
        smp_signed_s = {~cur_smp_s[SAMPLE_W-1], cur_smp_s[SAMPLE_W-2:0]};
        s_ext_s = P_W'(smp_signed_s);
        v_ext_s = {{(P_W-VOL_W){1'b0}}, cur_vol_s};
        prod_s  = s_ext_s * v_ext_s;

        shl_l_s = SHW'(acc_l_q) <<< SH;
        shl_r_s = SHW'(acc_r_q) <<< SH;

        case (state_q)
            ST_IDLE: begin
                if (tick_s) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                sh_smp_d = smp_q;
                sh_vol_d = vol_q;
                sh_pan_d = pan_q;
                acc_l_d  = {ACC_W{1'b0}};
                acc_r_d  = {ACC_W{1'b0}};
                k_d      = 3'd0;
                state_d  = ST_ACC;
            end
            ST_ACC: begin
                if (cur_pan_s[0]) begin
                    acc_l_d = acc_l_q + ACC_W'(prod_s);
                end else begin
                    acc_l_d = acc_l_q;
                end
                if (cur_pan_s[1]) begin
                    acc_r_d = acc_r_q + ACC_W'(prod_s);
                end else begin
                    acc_r_d = acc_r_q;
                end
                k_d = k_q + 3'd1;
                if (k_q == K_LAST) begin
                    state_d = ST_OUT;
                end else begin
                    state_d = ST_ACC;
                end
            end
            ST_OUT: begin
                snd_l_d  = sat_f(shl_l_s);
                snd_r_d  = sat_f(shl_r_s);
                strobe_d = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and data registers with synchronous active-low reset.
    always_ff @(posedge clk12mhz) begin
        if (!nRESET) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {DIV_W{1'b0}};
            k_q      <= 3'd0;
            acc_l_q  <= {ACC_W{1'b0}};
            acc_r_q  <= {ACC_W{1'b0}};
            snd_l_q  <= {OUT_W{1'b0}};
            snd_r_q  <= {OUT_W{1'b0}};
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                smp_q[i]    <= SMP_SILENCE;
                vol_q[i]    <= {VOL_W{1'b0}};
                pan_q[i]    <= 2'b11;
                sh_smp_q[i] <= SMP_SILENCE;
                sh_vol_q[i] <= {VOL_W{1'b0}};
                sh_pan_q[i] <= 2'b11;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            k_q      <= k_d;
            acc_l_q  <= acc_l_d;
            acc_r_q  <= acc_r_d;
            snd_l_q  <= snd_l_d;
            snd_r_q  <= snd_r_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
            smp_q    <= smp_d;
            vol_q    <= vol_d;
            pan_q    <= pan_d;
            sh_smp_q <= sh_smp_d;
            sh_vol_q <= sh_vol_d;
            sh_pan_q <= sh_pan_d;
        end
    end

    assign sndLeft    = snd_l_q;
    assign sndRight   = snd_r_q;
    assign snd_strobe = strobe_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_gs_mixer.sv
// tb_gs_mixer: scoreboard bench for gs_mixer (4-channel default and 8-channel
// instances on shared write buses). A reference model predicts each frame's
// output from the mixing rules; a monitor per instance checks every strobe.
module tb_gs_mixer;

    localparam int DIV = 272;

    logic       clk12mhz = 1'b0;
    logic       nRESET;
    logic       smp_we, vol_we, pan_we;
    logic [2:0] smp_ch, vol_ch, pan_ch;
    logic [7:0] smp_data;
    logic [5:0] vol_data;
    logic [1:0] pan_data;
    logic [15:0] l4, r4, l8, r8;
    logic        st4, st8, b4, b8;

    always #5 clk12mhz = ~clk12mhz;

    gs_mixer dut4 (
        .clk12mhz(clk12mhz), .nRESET(nRESET),
        .smp_we(smp_we), .smp_ch(smp_ch), .smp_data(smp_data),
        .vol_we(vol_we), .vol_ch(vol_ch), .vol_data(vol_data),
        .pan_we(pan_we), .pan_ch(pan_ch), .pan_data(pan_data),
        .sndLeft(l4), .sndRight(r4), .snd_strobe(st4), .busy(b4)
    );

    gs_mixer #(.CHANNELS(8), .OUT_W(16)) dut8 (
        .clk12mhz(clk12mhz), .nRESET(nRESET),
        .smp_we(smp_we), .smp_ch(smp_ch), .smp_data(smp_data),
        .vol_we(vol_we), .vol_ch(vol_ch), .vol_data(vol_data),
        .pan_we(pan_we), .pan_ch(pan_ch), .pan_data(pan_data),
        .sndLeft(l8), .sndRight(r8), .snd_strobe(st8), .busy(b8)
    );

    typedef struct {
        int l;
        int r;
        int t;
    } exp_t;

    exp_t q4[$];
    exp_t q8[$];
    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int m_smp[8];
    int m_vol[8];
    int m_pan[8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected output for one side: sum of (sample-128)*volume over routed
    // channels, scaled by 4 (16-bit output from 8+6 bit product), clamped.
    function automatic int mix(input int nch, input int side);
        int sum = 0;
        for (int i = 0; i < nch; i++) begin
            if (((m_pan[i] >> side) & 1) == 1) sum += (m_smp[i] - 128) * m_vol[i];
        end
        sum = sum * 4;
        if (sum > 32767) sum = 32767;
        if (sum < -32768) sum = -32768;
        return sum;
    endfunction

    // Reference model: count n is the divider value of the cycle just ended.
    // The cycle after each tick (count 0 again) is the snapshot cycle; its
    // expected result is visible 1+CHANNELS edges after its closing edge.
    initial begin : model
        int  n;
        bit  ticked;
        exp_t e;
        n = 0;
        ticked = 1'b0;
        forever begin
            @(posedge clk12mhz);
            cyc++;
            if (nRESET !== 1'b1) begin
                n = 0;
                ticked = 1'b0;
                q4.delete();
                q8.delete();
                for (int i = 0; i < 8; i++) begin
                    m_smp[i] = 128;
                    m_vol[i] = 0;
                    m_pan[i] = 3;
                end
            end else begin
                if (ticked && n == 0) begin
                    e.l = mix(4, 0); e.r = mix(4, 1); e.t = cyc + 1 + 4;
                    q4.push_back(e);
                    e.l = mix(8, 0); e.r = mix(8, 1); e.t = cyc + 1 + 8;
                    q8.push_back(e);
                end
                if (n == DIV - 1) ticked = 1'b1;
                if (smp_we) m_smp[smp_ch] = int'(smp_data);
                if (vol_we) m_vol[vol_ch] = int'(vol_data);
                if (pan_we) m_pan[pan_ch] = int'(pan_data);
                n = (n + 1) % DIV;
            end
        end
    end

    // Monitor for the 4-channel instance.
    initial begin : mon4
        exp_t e;
        forever begin
            @(negedge clk12mhz);
            if (st4 === 1'b1) begin
                if (q4.size() == 0) begin
                    chk("dut4 strobe with nothing pending", 1, 0);
                end else begin
                    e = q4.pop_front();
                    chk("dut4 sndLeft", int'($signed(l4)), e.l);
                    chk("dut4 sndRight", int'($signed(r4)), e.r);
                    chk("dut4 strobe cycle", cyc, e.t);
                end
            end else if (q4.size() > 0 && cyc > q4[0].t) begin
                chk("dut4 strobe missing, due cycle", q4[0].t, cyc);
                void'(q4.pop_front());
            end
        end
    end

    // Monitor for the 8-channel instance.
    initial begin : mon8
        exp_t e;
        forever begin
            @(negedge clk12mhz);
            if (st8 === 1'b1) begin
                if (q8.size() == 0) begin
                    chk("dut8 strobe with nothing pending", 1, 0);
                end else begin
                    e = q8.pop_front();
                    chk("dut8 sndLeft", int'($signed(l8)), e.l);
                    chk("dut8 sndRight", int'($signed(r8)), e.r);
                    chk("dut8 strobe cycle", cyc, e.t);
                end
            end else if (q8.size() > 0 && cyc > q8[0].t) begin
                chk("dut8 strobe missing, due cycle", q8[0].t, cyc);
                void'(q8.pop_front());
            end
        end
    end

    // Write sample, volume and pan of one channel in the same cycle.
    task automatic set_ch(input int ch, input int s, input int v, input int p);
        smp_we = 1'b1; smp_ch = 3'(ch); smp_data = 8'(s);
        vol_we = 1'b1; vol_ch = 3'(ch); vol_data = 6'(v);
        pan_we = 1'b1; pan_ch = 3'(ch); pan_data = 2'(p);
        @(negedge clk12mhz);
        smp_we = 1'b0; vol_we = 1'b0; pan_we = 1'b0;
    endtask

    task automatic wait_strobe();
        bit found = 1'b0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk12mhz);
            if (st4 === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) chk("strobe wait timeout", 0, 1);
    endtask

    task automatic wait_busy_acc();
        bit found = 1'b0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk12mhz);
            if (b4 === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        chk("busy seen", int'(found), 1);
        repeat (2) @(negedge clk12mhz);
    endtask

    // Release reset at a negedge (that cycle is cycle 1) and time the first strobe.
    task automatic release_and_time();
        int  n = 1;
        bit  found = 1'b0;
        nRESET = 1'b1;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk12mhz);
            n++;
            if (st4 === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        chk("first strobe cycle after release", found ? n : -1, 279);
    endtask

    initial begin : stim
        nRESET = 1'b0;
        smp_we = 1'b0; vol_we = 1'b0; pan_we = 1'b0;
        smp_ch = 3'd0; vol_ch = 3'd0; pan_ch = 3'd0;
        smp_data = 8'h00; vol_data = 6'd0; pan_data = 2'b00;

        // Reset state.
        repeat (3) @(negedge clk12mhz);
        chk("reset sndLeft", int'(l4), 0);
        chk("reset sndRight", int'(r4), 0);
        chk("reset strobe", int'(st4), 0);
        chk("reset busy", int'(b4), 0);
        chk("reset dut8 sndLeft", int'(l8), 0);
        chk("reset dut8 busy", int'(b8), 0);
        release_and_time();

        // Single channel, full positive.
        set_ch(0, 'hFF, 63, 3);
        wait_strobe();
        chk("single channel left", int'($signed(l4)), 32004);

        // Positive saturation on all channels.
        for (int c = 0; c < 8; c++) set_ch(c, 'hFF, 63, 3);
        wait_strobe();
        chk("positive saturation", int'($signed(r4)), 32767);

        // Negative saturation on all channels.
        for (int c = 0; c < 8; c++) set_ch(c, 'h00, 63, 3);
        wait_strobe();
        chk("negative saturation", int'($signed(l4)), -32768);

        // Pan routing.
        set_ch(0, 'hFF, 63, 1);
        set_ch(1, 'h00, 63, 2);
        for (int c = 2; c < 8; c++) set_ch(c, 'h80, 0, 3);
        wait_strobe();
        chk("pan left", int'($signed(l4)), 32004);
        chk("pan right", int'($signed(r4)), -32256);

        // Write during ACC only affects the next frame; bad index is ignored.
        set_ch(0, 'hFF, 63, 3);
        set_ch(1, 'h80, 0, 3);
        wait_busy_acc();
        smp_we = 1'b1; smp_ch = 3'd0; smp_data = 8'h00;
        @(negedge clk12mhz);
        smp_ch = 3'd5; smp_data = 8'h11;
        @(negedge clk12mhz);
        smp_we = 1'b0;
        wait_strobe();
        chk("frame with write in ACC", int'($signed(l4)), 32004);
        wait_strobe();
        chk("frame after write in ACC", int'($signed(l4)), -32256);

        // Randomized writes across several frames, including during busy.
        for (int i = 0; i < 6 * DIV; i++) begin
            smp_we = ($urandom_range(0, 5) == 0);
            vol_we = ($urandom_range(0, 5) == 0);
            pan_we = ($urandom_range(0, 7) == 0);
            smp_ch = 3'($urandom_range(0, 7));
            vol_ch = 3'($urandom_range(0, 7));
            pan_ch = 3'($urandom_range(0, 7));
            smp_data = 8'($urandom_range(0, 255));
            vol_data = 6'($urandom_range(0, 63));
            pan_data = 2'($urandom_range(0, 3));
            @(negedge clk12mhz);
        end
        smp_we = 1'b0; vol_we = 1'b0; pan_we = 1'b0;
        set_ch(0, 'hFF, 63, 3);
        wait_strobe();

        // Mid-frame reset: no strobe for the aborted frame, outputs cleared.
        wait_busy_acc();
        nRESET = 1'b0;
        @(negedge clk12mhz);
        chk("mid-frame reset sndLeft", int'(l4), 0);
        chk("mid-frame reset sndRight", int'(r4), 0);
        chk("mid-frame reset strobe", int'(st4), 0);
        chk("mid-frame reset busy", int'(b4), 0);
        chk("mid-frame reset dut8 sndLeft", int'(l8), 0);
        chk("mid-frame reset dut8 strobe", int'(st8), 0);
        release_and_time();

        repeat (20) @(negedge clk12mhz);
        chk("dut4 pending frames", q4.size(), 0);
        chk("dut8 pending frames", q8.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/gs_mixer.md
# gs_mixer

Parametrised N-channel sample mixer for the General Sound block. It takes the per-channel 8-bit DAC samples and 6-bit volumes that the sound CPU writes and adds a per-channel stereo pan. Once per sample period it runs a time-multiplexed multiply-accumulate and produces saturated signed stereo PCM with a new-sample strobe. It sits between the sound CPU's DAC/volume register decode and the board audio output, and uses one multiplier instead of one per channel.

## Interface
- CHANNELS, 4, number of mixed channels, 1..8
- SAMPLE_W, 8, sample width, offset-binary (0x80 = silence)
- VOL_W, 6, volume width, unsigned
- OUT_W, 16, output width, signed; must be >= SAMPLE_W+VOL_W
- SAMPLE_DIV, 272, clk12mhz cycles per output sample (about 44.1 kHz); must be >= CHANNELS+4

Ports:
- clk12mhz  in  1  system clock; all logic on its rising edge
- nRESET  in  1  synchronous, active-low reset
- smp_we  in  1  sample write strobe
- smp_ch  in  3  sample channel index
- smp_data  in  SAMPLE_W  sample value
- vol_we  in  1  volume write strobe
- vol_ch  in  3  volume channel index
- vol_data  in  VOL_W  volume value
- pan_we  in  1  pan write strobe
- pan_ch  in  3  pan channel index
- pan_data  in  2  bit0 = route to left, bit1 = route to right
- sndLeft  out  OUT_W  signed left sample, registered
- sndRight  out  OUT_W  signed right sample, registered
- snd_strobe  out  1  one-cycle pulse when sndLeft/sndRight update
- busy  out  1  high while a mix frame is in progress

## Operation
- Live register files per channel: sample, volume, pan. Each `*_we` writes its own file at the clock edge.
  - A write with index >= CHANNELS is ignored.
  - Writes on different ports in the same cycle all take effect.
- Free-running divider counts 0..SAMPLE_DIV-1. The cycle with count == SAMPLE_DIV-1 is the tick; the divider wraps to 0.
- FSM states IDLE, LOAD, ACC, OUT:
  - IDLE: on tick go to LOAD.
  - LOAD: copy all live registers into shadow registers (pre-edge values). Clear accL and accR. Set k=0 and go to ACC.
  - ACC: p = signed(sample[k]) * vol[k].
    - signed() inverts the sample MSB, giving the range -128..+127.
    - If pan[k][0], accL += p. If pan[k][1], accR += p.
    - k++. After k = CHANNELS-1, go to OUT.
  - OUT: sndX <= sat(accX <<< (OUT_W-SAMPLE_W-VOL_W)). Go to IDLE.
- Width rules:
  - p is SAMPLE_W+VOL_W bits signed.
  - Accumulator is SAMPLE_W+VOL_W+3 bits signed, which covers 8 channels without wrap.
  - Shift is done at accumulator width plus the shift amount.
  - sat clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Writes during LOAD..OUT update live registers only. They affect the next frame, never the current one.
- busy is high in LOAD, ACC and OUT.

## Timing
- Tick in cycle T. LOAD in T+1. ACC in T+2..T+1+CHANNELS. OUT in T+2+CHANNELS.
- New sndLeft/sndRight and snd_strobe=1 are visible in T+3+CHANNELS. snd_strobe lasts exactly one cycle.
- Output period is exactly SAMPLE_DIV cycles. The tick never arrives while busy.
- Reset (any cycle, including mid-frame) applies at the next edge:
  - FSM to IDLE, divider to 0, accumulators to 0.
  - samples 0x80, volumes 0, pans 2'b11.
  - sndLeft = sndRight = 0, snd_strobe = 0, busy = 0.
  - No strobe for an aborted frame. The first tick after reset is at count SAMPLE_DIV-1, i.e. SAMPLE_DIV cycles after release.

## Test plan
- Reset check, default parameters:
  - Hold nRESET low 3 cycles, release -> outputs 0, strobe 0, busy 0.
  - First strobe 279 cycles after release (272 + 4 + 3); sndLeft = sndRight = 0.
- Single channel: ch0 sample 0xFF, vol 63, pan 11, others silent -> sndLeft = sndRight = 32004 (127*63*4).
- Positive saturation: all 4 channels 0xFF, vol 63 -> both outputs 32767.
- Negative saturation: all 4 channels 0x00, vol 63 -> both outputs -32768.
- Pan routing: ch0 0xFF/63 pan 01, ch1 0x00/63 pan 10 -> sndLeft 32004, sndRight -32256.
- Writes during busy and bad index:
  - Write ch0 sample 0x00 during ACC of a frame with ch0 = 0xFF/63 -> that frame gives 32004; next frame gives -32256.
  - Write to smp_ch = 5 -> no change.
- Mid-frame reset: assert nRESET during ACC -> no strobe; all outputs 0 the next cycle.
- Regression: CHANNELS=8, OUT_W=16 with all channels 0xFF/63 -> 32767.
